// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles the hazard-detection inputs and the pipeline-register control
// outputs of pipeline_hazard_ctrl.
//   master : pipeline side; drives hazard info, receives enables/flushes
//   slave  : hazard controller side
// Inputs to the controller : MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID,
//                            BranchTaken_EX, MemReq_MEM, MemReady
// Outputs of the controller: PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
//                            IDEX_Flush, EXMEM_Write, MEMWB_Bubble, MemError,
//                            StallCycles (only when PIPE_CTRL_PERF_EN is defined)
interface pipeline_hazard_ctrl_if;
  logic        MemRead_EX;
  logic [4:0]  Rt_EX;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic        UsesRt_ID;
  logic        BranchTaken_EX;
  logic        MemReq_MEM;
  logic        MemReady;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Write;
  logic        IDEX_Flush;
  logic        EXMEM_Write;
  logic        MEMWB_Bubble;
  logic        MemError;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCycles;
`endif

  modport master (
    output MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID, BranchTaken_EX,
           MemReq_MEM, MemReady,
`ifdef PIPE_CTRL_PERF_EN
    input  StallCycles,
`endif
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MEMWB_Bubble, MemError
  );

  modport slave (
    input  MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID, BranchTaken_EX,
           MemReq_MEM, MemReady,
`ifdef PIPE_CTRL_PERF_EN
    output StallCycles,
`endif
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, MEMWB_Bubble, MemError
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Control for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of a
// 5-stage pipeline: load-use stalls, taken-branch flushes and data-memory
// wait states. Enables/flushes are combinational from the FSM state and the
// current inputs so they reach the register pins in the same cycle.
// Ports:
//   Clk    - clock, rising edge
//   Reset  - synchronous, active-high; forces all enables/flushes low
//   bus    - pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs)
// Parameters:
//   FLUSH_CYCLES - IF/ID flush cycles after a taken branch (>=1)
//   MEM_TIMEOUT  - MEM_WAIT cycles before the access is aborted (1..15)
// Optional feature: define PIPE_CTRL_PERF_EN to add the 32-bit saturating
// StallCycles counter (cycles with PCWrite low).
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic                   Clk,
  input logic                   Reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t         state;
  logic [3:0]     waitCnt;
  logic [FCW-1:0] flushCnt;
  logic           memError;

  logic memWaitCond, branchCond, loadUseCond;
  logic stallMem, inFlush, doBranch, doLoadUse;
  logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, memwbBubble;

  assign memWaitCond = bus.MemReq_MEM & ~bus.MemReady;
  assign branchCond  = bus.BranchTaken_EX;
  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign loadUseCond = bus.MemRead_EX & (bus.Rt_EX != 5'd0) &
                       ((bus.Rt_EX == bus.Rs_ID) |
                        (bus.UsesRt_ID & (bus.Rt_EX == bus.Rt_ID)));

  // In MEM_WAIT the freeze holds until MemReady regardless of MemReq_MEM;
  // on the ready cycle the decision falls through to the normal RUN rules.
  assign stallMem  = (state == MEM_WAIT) ? ~bus.MemReady : memWaitCond;
  assign inFlush   = (state == FLUSH);
  assign doBranch  = ~stallMem & branchCond;
  // While flushing, ID holds a NOP, so a load-use match there is spurious.
  assign doLoadUse = ~stallMem & ~branchCond & ~inFlush & loadUseCond;

  always_comb begin
    pcWrite     = 1'b0;
    ifidWrite   = 1'b0;
    ifidFlush   = 1'b0;
    idexWrite   = 1'b0;
    idexFlush   = 1'b0;
    exmemWrite  = 1'b0;
    memwbBubble = 1'b0;
    if (!Reset) begin
      pcWrite     = ~stallMem & ~doLoadUse;
      ifidWrite   = ~stallMem & ~doLoadUse;
      ifidFlush   = ~stallMem & (doBranch | inFlush);
      idexWrite   = ~stallMem;
      idexFlush   = doBranch | doLoadUse;
      exmemWrite  = ~stallMem;
      // The cycle after a timeout also bubbles so the aborted access never writes back.
      memwbBubble = stallMem | memError;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= RUN;
      waitCnt  <= 4'd0;
      flushCnt <= '0;
      memError <= 1'b0;
    end else begin
      memError <= 1'b0;
      case (state)
        MEM_WAIT: begin
          if (!bus.MemReady) begin
            if (waitCnt == 4'(MEM_TIMEOUT - 1)) begin
              state    <= RUN;
              waitCnt  <= 4'd0;
              flushCnt <= '0;
              memError <= 1'b1;
            end else begin
              waitCnt <= waitCnt + 4'd1;
            end
          end else if (branchCond && FLUSH_CYCLES > 1) begin
            state    <= FLUSH;
            flushCnt <= FCW'(FLUSH_CYCLES - 1);
          end else if (branchCond) begin
            state    <= RUN;
            flushCnt <= '0;
          end else if (flushCnt != '0) begin
            // Resume a flush sequence that was preempted by the memory wait.
            state <= FLUSH;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          // RUN and FLUSH share the same priority order; flushCnt survives a
          // memory-wait preemption untouched.
          if (memWaitCond) begin
            state   <= MEM_WAIT;
            waitCnt <= 4'd0;
          end else if (branchCond && FLUSH_CYCLES > 1) begin
            state    <= FLUSH;
            flushCnt <= FCW'(FLUSH_CYCLES - 1);
          end else if (branchCond) begin
            state    <= RUN;
            flushCnt <= '0;
          end else if (state == FLUSH) begin
            if (flushCnt <= FCW'(1)) begin
              state    <= RUN;
              flushCnt <= '0;
            end else begin
              flushCnt <= flushCnt - FCW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCycles;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallCycles <= 32'd0;
    end else if (!pcWrite && stallCycles != 32'hFFFF_FFFF) begin
      stallCycles <= stallCycles + 32'd1;
    end
  end

  assign bus.StallCycles = stallCycles;
`endif

  assign bus.PCWrite      = pcWrite;
  assign bus.IFID_Write   = ifidWrite;
  assign bus.IFID_Flush   = ifidFlush;
  assign bus.IDEX_Write   = idexWrite;
  assign bus.IDEX_Flush   = idexFlush;
  assign bus.EXMEM_Write  = exmemWrite;
  assign bus.MEMWB_Bubble = memwbBubble;
  assign bus.MemError     = memError;

endmodule
